// File: rtl/sound_latch.sv
// rtl/sound_latch.sv - M68K-to-Z80 sound command latch with DTACK generation.
// Optional command FIFO selected by defining SOUND_LATCH_FIFO_EN.
module sound_latch #(
  parameter int DTACK_WAIT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m68k_latch_cs,
  input  logic       m68k_sound_cs,
  input  logic [7:0] m68k_din,
  output logic [7:0] m68k_dout,
  output logic       m68k_dtack_n,
  input  logic       z80_latch_cs,
  input  logic       z80_rd_n,
  input  logic       z80_wr_n,
  output logic [7:0] z80_dout,
  output logic       z80_nmi_n
);

  if (DTACK_WAIT < 1 || DTACK_WAIT > 7) begin : g_bad_wait
    $error("DTACK_WAIT must be 1..7");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  // bit0 write select, bit1 status select, bit2 Z80 write strobe
  logic [2:0] sel_now;
  logic [2:0] hist_q;
  logic [2:0] mask_q;
  logic [2:0] rise;
  logic       wr_evt, rd_evt, clr_evt;

  assign sel_now = {z80_latch_cs & ~z80_wr_n, m68k_sound_cs, m68k_latch_cs};
  assign rise    = sel_now & ~hist_q & ~mask_q;
  assign wr_evt  = rise[0];
  assign rd_evt  = rise[1];
  assign clr_evt = rise[2];

  // mask_q suppresses selects that were already high while reset was applied
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 3'b000;
      mask_q <= sel_now;
    end else begin
      hist_q <= sel_now;
      mask_q <= mask_q & sel_now;
    end
  end

  logic       ovr_q, ovr_d;
  logic       ovr_set;
  logic       pending_q;
  logic       pending_d;
  logic [7:0] head;
  logic       nmi_n_q;

`ifdef SOUND_LATCH_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          full, push, pop;

  assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop     = clr_evt & (cnt_q != '0);
  assign push    = wr_evt & (~full | pop);
  assign ovr_set = wr_evt & full & ~pop;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  assign pending_d = (cnt_d != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  // When full, push and pop share a slot: the old head leaves as the new tail lands.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= m68k_din;
  end
`else
  logic [7:0] latch_q;

  assign pending_d = wr_evt | (pending_q & ~clr_evt);
  assign ovr_set   = wr_evt & pending_q & ~clr_evt;
  assign head      = latch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q <= 8'h00;
    end else if (wr_evt) begin
      latch_q <= m68k_din;
    end
  end
`endif

  assign ovr_d = ovr_set | (ovr_q & ~rd_evt);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      ovr_q     <= 1'b0;
      nmi_n_q   <= 1'b1;
    end else begin
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      nmi_n_q   <= ~pending_d;
    end
  end

  assign m68k_dout = {6'b000000, ovr_q, pending_q};
  assign z80_dout  = (z80_latch_cs & ~z80_rd_n) ? head : 8'hFF;
  assign z80_nmi_n = nmi_n_q;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} dt_state_e;

  dt_state_e  state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic       any_sel;

  assign any_sel = m68k_latch_cs | m68k_sound_cs;

  // The rise cycle itself counts as the first wait cycle, so DTACK_WAIT=1 skips WAIT.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (wr_evt || rd_evt) begin
          wcnt_d  = 3'd1;
          state_d = (DTACK_WAIT <= 1) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!any_sel) begin
          state_d = S_IDLE;
        end else if (wcnt_q == 3'(DTACK_WAIT - 1)) begin
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_ACK: begin
        if (!any_sel) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign m68k_dtack_n = ~((state_q == S_ACK) & any_sel);

endmodule
